// File: rtl/train_pkg.sv
// Shared types for the train controller: state codes and the duration width
// that the downstream timer also uses.
package train_pkg;

    localparam int TW = 19;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_ACCEL        = 4'd1,
        S_CRUISE       = 4'd2,
        S_BRAKE        = 4'd3,
        S_DOOR_OPENING = 4'd4,
        S_DWELL        = 4'd5,
        S_DOOR_CLOSING = 4'd6,
        S_EMERGENCY    = 4'd7
    } state_e;

endpackage

// File: rtl/train_sequencer_if.sv
// Sensor inputs, timer link and actuator outputs of the train sequencer.
interface train_sequencer_if;

    logic                    start;
    logic                    station;
    logic                    obstruct;
    logic                    emergency;
    logic                    timer_done;
    logic [train_pkg::TW-1:0] t;
    logic [3:0]              present_state;
    logic                    motor;
    logic                    brake;
    logic                    door_cmd;
    logic                    alarm;

    modport master (
        input  start, station, obstruct, emergency, timer_done,
        output t, present_state, motor, brake, door_cmd, alarm
    );

    modport slave (
        output start, station, obstruct, emergency, timer_done,
        input  t, present_state, motor, brake, door_cmd, alarm
    );

endinterface

// File: rtl/train_sequencer_done_qualifier.sv
// Masks timer_done for GUARD edges after every state change, so a stale done
// from the previous phase cannot advance the new one.
module done_qualifier #(
    parameter int unsigned GUARD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic state_change,
    input  logic timer_done,
    output logic done_q
);

    logic [2:0] guard_cnt_q;
    logic [2:0] guard_cnt_d;

    always_comb begin
        guard_cnt_d = guard_cnt_q;
        if (state_change) begin
            guard_cnt_d = 3'(GUARD);
        end else if (guard_cnt_q != 3'd0) begin
            guard_cnt_d = guard_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            guard_cnt_q <= 3'd0;
        end else begin
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign done_q = timer_done && (guard_cnt_q == 3'd0);

endmodule

// File: rtl/train_sequencer.sv
// Train phase sequencer: steps through accelerate/cruise/brake/door/dwell,
// feeds the duration timer and decodes actuator commands from the state.
module train_sequencer
    import train_pkg::*;
#(
    parameter logic [TW-1:0] T_ACCEL      = 19'd400000,
    parameter logic [TW-1:0] T_BRAKE      = 19'd300000,
    parameter logic [TW-1:0] T_DOOR_OPEN  = 19'd100000,
    parameter logic [TW-1:0] T_DWELL      = 19'd250000,
    parameter logic [TW-1:0] T_DOOR_CLOSE = 19'd120000,
    parameter logic [TW-1:0] T_ALARM      = 19'd500000,
    parameter int unsigned   GUARD        = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    train_sequencer_if.master  bus
);

    state_e state_q;
    state_e state_d;
    logic   state_change;
    logic   done_q;

    assign state_change = (state_d != state_q);

    done_qualifier #(
        .GUARD (GUARD)
    ) u_done_qualifier (
        .clk          (clk),
        .rst_n        (rst_n),
        .state_change (state_change),
        .timer_done   (bus.timer_done),
        .done_q       (done_q)
    );

    always_comb begin
        state_d = state_q;
        if (bus.emergency && state_q != S_EMERGENCY &&
            state_q inside {S_IDLE, S_ACCEL, S_CRUISE, S_BRAKE,
                            S_DOOR_OPENING, S_DWELL, S_DOOR_CLOSING}) begin
            state_d = S_EMERGENCY;
        end else begin
            case (state_q)
                S_IDLE:         if (bus.start)   state_d = S_ACCEL;
                S_ACCEL:        if (done_q)      state_d = S_CRUISE;
                S_CRUISE:       if (bus.station) state_d = S_BRAKE;
                S_BRAKE:        if (done_q)      state_d = S_DOOR_OPENING;
                S_DOOR_OPENING: if (done_q)      state_d = S_DWELL;
                S_DWELL:        if (done_q)      state_d = S_DOOR_CLOSING;
                S_DOOR_CLOSING: begin
                    // A reopen must win over the close finishing on the same edge.
                    if (bus.obstruct) begin
                        state_d = S_DOOR_OPENING;
                    end else if (done_q) begin
                        state_d = S_IDLE;
                    end
                end
                S_EMERGENCY:    if (done_q && !bus.emergency) state_d = S_IDLE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend only on the state register; unused codes decode as IDLE.
    always_comb begin
        bus.t        = '0;
        bus.motor    = 1'b0;
        bus.brake    = 1'b1;
        bus.door_cmd = 1'b0;
        bus.alarm    = 1'b0;
        case (state_q)
            S_ACCEL: begin
                bus.t     = T_ACCEL;
                bus.motor = 1'b1;
                bus.brake = 1'b0;
            end
            S_CRUISE: begin
                bus.motor = 1'b1;
                bus.brake = 1'b0;
            end
            S_BRAKE: begin
                bus.t = T_BRAKE;
            end
            S_DOOR_OPENING: begin
                bus.t        = T_DOOR_OPEN;
                bus.brake    = 1'b0;
                bus.door_cmd = 1'b1;
            end
            S_DWELL: begin
                bus.t        = T_DWELL;
                bus.brake    = 1'b0;
                bus.door_cmd = 1'b1;
            end
            S_DOOR_CLOSING: begin
                bus.t     = T_DOOR_CLOSE;
                bus.brake = 1'b0;
            end
            S_EMERGENCY: begin
                bus.t     = T_ALARM;
                bus.alarm = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.present_state = state_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Randomised and directed checking of train_sequencer against a phase-level
// reference model of the trip rules.
module tb_train_sequencer;
    import train_pkg::*;

    localparam int GUARD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    train_sequencer_if bus ();

    train_sequencer #(
        .T_ACCEL      (19'd10),
        .T_BRAKE      (19'd8),
        .T_DOOR_OPEN  (19'd4),
        .T_DWELL      (19'd6),
        .T_DOOR_CLOSE (19'd5),
        .T_ALARM      (19'd12),
        .GUARD        (GUARD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_state = 0;
    int m_age = GUARD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int t_of(input int st);
        case (st)
            1: return 10;
            3: return 8;
            4: return 4;
            5: return 6;
            6: return 5;
            7: return 12;
            default: return 0;
        endcase
    endfunction

    // {motor, brake, door_cmd, alarm}
    function automatic int outs_of(input int st);
        int motor = (st == 1 || st == 2) ? 1 : 0;
        int brk   = (st == 0 || st == 3 || st == 7) ? 1 : 0;
        int door  = (st == 4 || st == 5) ? 1 : 0;
        int alarm = (st == 7) ? 1 : 0;
        return motor * 8 + brk * 4 + door * 2 + alarm;
    endfunction

    function automatic int model_next(input int st, input logic s, input logic sta,
                                      input logic obs, input logic em, input logic td);
        logic dq = td && (m_age >= GUARD);
        if (st > 7) return 0;
        if (em && st != 7) return 7;
        case (st)
            0: return s ? 1 : 0;
            1: return dq ? 2 : 1;
            2: return sta ? 3 : 2;
            3: return dq ? 4 : 3;
            4: return dq ? 5 : 4;
            5: return dq ? 6 : 5;
            6: return obs ? 4 : (dq ? 0 : 6);
            default: return (dq && !em) ? 0 : 7;
        endcase
    endfunction

    task automatic compare_all();
        check("state", 32'(bus.present_state), 32'(m_state));
        check("t", 32'(bus.t), 32'(t_of(m_state)));
        check("outs", 32'({bus.motor, bus.brake, bus.door_cmd, bus.alarm}), 32'(outs_of(m_state)));
    endtask

    task automatic step(input logic rn, input logic s, input logic sta,
                        input logic obs, input logic em, input logic td);
        int nx;
        rst_n          = rn;
        bus.start      = s;
        bus.station    = sta;
        bus.obstruct   = obs;
        bus.emergency  = em;
        bus.timer_done = td;
        @(posedge clk);
        if (!rn) begin
            m_state = 0;
            m_age   = GUARD;
        end else begin
            nx = model_next(m_state, s, sta, obs, em, td);
            if (nx != m_state) m_age = 0;
            else if (m_age < GUARD) m_age++;
            m_state = nx;
        end
        #1;
        compare_all();
    endtask

    task automatic done_run(input int target);
        repeat (GUARD + 1) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("phase_state", 32'(bus.present_state), 32'(target));
        check("phase_t", 32'(bus.t), 32'(t_of(target)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.station = 1'b0; bus.obstruct = 1'b0;
        bus.emergency = 1'b0; bus.timer_done = 1'b0;

        // Reset held with start asserted
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", 32'(bus.present_state), 32'd0);
        check("rst_t", 32'(bus.t), 32'd0);
        check("rst_outs", 32'({bus.motor, bus.brake, bus.door_cmd, bus.alarm}), 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_state", 32'(bus.present_state), 32'd1);
        check("start_t", 32'(bus.t), 32'd10);

        // Guard: done held from ACCEL entry
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("guard1", 32'(bus.present_state), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("guard2", 32'(bus.present_state), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cruise_state", 32'(bus.present_state), 32'd2);
        check("cruise_motor", 32'(bus.motor), 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("brake_state", 32'(bus.present_state), 32'd3);
        check("brake_t", 32'(bus.t), 32'd8);
        done_run(4);
        done_run(5);
        done_run(6);

        // Obstruct together with done in DOOR_CLOSING
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("reopen_state", 32'(bus.present_state), 32'd4);
        check("reopen_door", 32'(bus.door_cmd), 32'd1);
        done_run(5);
        done_run(6);
        done_run(0);

        // Emergency from CRUISE
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        done_run(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("emerg_state", 32'(bus.present_state), 32'd7);
        check("emerg_outs", 32'({bus.motor, bus.brake, bus.door_cmd, bus.alarm}), 32'd5);
        check("emerg_t", 32'(bus.t), 32'd12);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("emerg_hold", 32'(bus.present_state), 32'd7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("emerg_exit", 32'(bus.present_state), 32'd0);

        // Illegal code recovery, forced while idle with no start
        force dut.state_q = state_e'(4'd12);
        #1;
        check("illegal_code", 32'(bus.present_state), 32'd12);
        check("illegal_outs", 32'({bus.motor, bus.brake, bus.door_cmd, bus.alarm}), 32'd4);
        check("illegal_t", 32'(bus.t), 32'd0);
        check("illegal_next", 32'(dut.state_d), 32'd0);
        release dut.state_q;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("illegal_recover", 32'(bus.present_state), 32'd0);
        m_age = 0;

        // Randomised operation against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) != 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(4) == 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(39) == 0),
                 ($urandom_range(1) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/train_sequencer.md
# train_sequencer

Top-level train control state machine that sits directly upstream of the duration timer. It steps the train through accelerate, cruise, brake, door and dwell phases, and drives the timer's 19-bit duration input and 4-bit state code. It consumes the timer's done flag to advance, and commands the motor, brake, doors and alarm.

## Interface
- T_ACCEL, 400000, acceleration phase length in clk cycles
- T_BRAKE, 300000, braking phase length
- T_DOOR_OPEN, 100000, door opening time
- T_DWELL, 250000, doors-open dwell at station
- T_DOOR_CLOSE, 120000, door closing time
- T_ALARM, 500000, minimum emergency alarm time
- GUARD, 2, cycles after entering a timed state during which timer_done is ignored (1..7)
- All T_* values are nonzero, < 2^19, and pairwise distinct.
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  departure request, level
- station  in  1  station-approach sensor, level
- obstruct  in  1  door obstruction sensor, level
- emergency  in  1  emergency stop, level
- timer_done  in  1  done flag from downstream timer
- t  out  19  duration presented to timer
- present_state  out  4  current state code
- motor  out  1  traction on
- brake  out  1  brake applied
- door_cmd  out  1  doors commanded open
- alarm  out  1  alarm sounder

## Operation
- Inputs are synchronous to clk. Synchronisers live outside this block.
- State codes:
  - IDLE=0, ACCEL=1, CRUISE=2, BRAKE=3, DOOR_OPENING=4, DWELL=5, DOOR_CLOSING=6, EMERGENCY=7.
  - Codes 8–15 are unused and recover to IDLE on the next edge.
- Qualified done: done_q = timer_done && guard_cnt==0.
  - guard_cnt loads GUARD on every state change and decrements to 0.
- Transitions, highest priority first:
  - emergency in any non-EMERGENCY state → EMERGENCY.
  - IDLE: start → ACCEL.
  - ACCEL: done_q → CRUISE.
  - CRUISE: station → BRAKE.
  - BRAKE: done_q → DOOR_OPENING.
  - DOOR_OPENING: done_q → DWELL.
  - DWELL: done_q → DOOR_CLOSING.
  - DOOR_CLOSING: obstruct → DOOR_OPENING (beats done_q); done_q → IDLE.
  - EMERGENCY: done_q && !emergency → IDLE. Otherwise stay; emergency held does not re-enter or restart the alarm time.
- t per state:
  - ACCEL=T_ACCEL, BRAKE=T_BRAKE, DOOR_OPENING=T_DOOR_OPEN, DWELL=T_DWELL, DOOR_CLOSING=T_DOOR_CLOSE, EMERGENCY=T_ALARM.
  - IDLE and CRUISE: t=0.
  - The downstream timer restarts on a change of t. Distinct T_* values guarantee every timed entry presents a new value, including the obstruct reopen.
- Output decode:
  - motor = ACCEL|CRUISE.
  - brake = IDLE|BRAKE|EMERGENCY.
  - door_cmd = DOOR_OPENING|DWELL.
  - alarm = EMERGENCY.

## Timing
- Reset (rst_n low at an edge):
  - present_state=0, t=0, brake=1, motor=door_cmd=alarm=0, guard_cnt=0.
  - Reset mid-operation aborts any phase on that edge.
- Everything is registered. Inputs sampled at edge k change state, t and all outputs after edge k. Latency is one cycle; there are no combinational input-to-output paths.
- t and present_state change on the same edge.
- timer_done is ignored for GUARD edges after entry, covering the downstream timer's one-cycle reload lag.
- Simultaneous events:
  - emergency beats all other inputs.
  - obstruct beats done_q in DOOR_CLOSING.
  - start arriving with done_q in DOOR_CLOSING is ignored until IDLE.
- station outside CRUISE is ignored. start outside IDLE is ignored.
- No wrap-around: the only counter is guard_cnt, which saturates at 0.

## Structure
- Shared package train_pkg holds:
  - the 4-bit state enum and its codes;
  - localparam TW=19 for the duration width, shared with the timer.
- One sub-module, done_qualifier: guard_cnt plus the done_q gate. Ports: clk, rst_n, state_change, timer_done, done_q.
- The top holds the state register, next-state logic, t mux and output decode.

## Test plan
Bench parameters: T_ACCEL=10, T_BRAKE=8, T_DOOR_OPEN=4, T_DWELL=6, T_DOOR_CLOSE=5, T_ALARM=12, GUARD=2. The bench drives timer_done directly.

- Reset: hold rst_n=0 for 3 cycles with start=1 → state 0, t=0, brake=1, others 0. On the first edge after release, state=1 and t=10.
- Full trip: start → ACCEL. done → CRUISE, t=0, motor=1. station → BRAKE, t=8. Then done → 4 (t=4), → 5 (t=6), → 6 (t=5), → IDLE.
- Guard: timer_done held at 1 on ACCEL entry → state stays 1 for exactly 2 edges, then moves to 2.
- Obstruct: obstruct and timer_done together in state 6 → state 4, t=4, door_cmd=1.
- Emergency in CRUISE → state 7, alarm=1, brake=1, motor=0, t=12. done with emergency=1 → stays 7. Drop emergency → IDLE on the next edge.
- Illegal code forced to 12 → IDLE after one edge. Outputs are decoded as IDLE during recovery.
